// File: rtl/loop_filter_regs_mc_if.sv
// rtl/loop_filter_regs_mc_if.sv - register bus interface for the multi-channel loop filter bank
// Purpose: bundles the chip-select, byte-lane strobes, address and data of the register bus.
// Signals: cs (block select), wr0..wr3 (byte-lane write strobes), addr[12:0] (byte address),
//          dataIn[31:0] (write data), dataOut[31:0] (registered read data, driven by the slave).
interface loop_filter_regs_mc_if;
  logic        cs;
  logic        wr0;
  logic        wr1;
  logic        wr2;
  logic        wr3;
  logic [12:0] addr;
  logic [31:0] dataIn;
  logic [31:0] dataOut;

  modport master (output cs, wr0, wr1, wr2, wr3, addr, dataIn, input dataOut);
  modport slave  (input cs, wr0, wr1, wr2, wr3, addr, dataIn, output dataOut);
endinterface

// File: rtl/loop_filter_regs_mc.sv
// rtl/loop_filter_regs_mc.sv - double-buffered register bank for NUM_CHANNELS loop filters
// Purpose: bus writes land in per-channel shadow registers and move atomically to the active
//          outputs on an apply command, aligned to each channel's loopEn. Also provides a coherent
//          integrator snapshot and sticky loss-of-lock / limit-sanity flags.
// Ports:   busClk, reset (sync, active-high); bus (slave modport: cs, wr0..wr3, addr, dataIn, dataOut);
//          loopEn, lagAccum, lockStatus (per-channel inputs); per-channel active control, gain,
//          limit, loop data and lock detector outputs; applyPending.
// Option:  LOOPREG_AUTO_APPLY_EN - a wr3 write to offsets 0-5 also requests an apply for that channel.
module loop_filter_regs_mc #(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_BITS      = 2,
  parameter int CH_SEL_LSB   = 5
) (
  input  logic                       busClk,
  input  logic                       reset,
  loop_filter_regs_mc_if.slave       bus,
  input  logic [NUM_CHANNELS-1:0]    loopEn,
  input  logic [32*NUM_CHANNELS-1:0] lagAccum,
  input  logic [NUM_CHANNELS-1:0]    lockStatus,
  output logic [NUM_CHANNELS-1:0]    zeroError,
  output logic [NUM_CHANNELS-1:0]    invertError,
  output logic [NUM_CHANNELS-1:0]    ctrl2,
  output logic [NUM_CHANNELS-1:0]    ctrl4,
  output logic [NUM_CHANNELS-1:0]    clearAccum,
  output logic [2*NUM_CHANNELS-1:0]  acqTrackControl,
  output logic [5*NUM_CHANNELS-1:0]  lagExp,
  output logic [5*NUM_CHANNELS-1:0]  leadExp,
  output logic [8*NUM_CHANNELS-1:0]  lagMan,
  output logic [8*NUM_CHANNELS-1:0]  leadMan,
  output logic [32*NUM_CHANNELS-1:0] upperLimit,
  output logic [32*NUM_CHANNELS-1:0] lowerLimit,
  output logic [32*NUM_CHANNELS-1:0] loopData,
  output logic [16*NUM_CHANNELS-1:0] lockCount,
  output logic [12*NUM_CHANNELS-1:0] syncThreshold,
  output logic [NUM_CHANNELS-1:0]    applyPending
);
  localparam int NREG = 6;  // offsets 0..5 are double-buffered

  logic [3:0]         strobe;
  logic [CH_BITS-1:0] ch;
  logic [2:0]         off;
  logic               ch_ok, wr_any, cmd_wr, w1c_wr, snap_wr;
  logic               unused_addr;

  assign strobe      = {bus.wr3, bus.wr2, bus.wr1, bus.wr0};
  assign ch          = bus.addr[CH_SEL_LSB +: CH_BITS];
  assign off         = bus.addr[4:2];
  assign ch_ok       = ({1'b0, ch} < (CH_BITS+1)'(NUM_CHANNELS));
  assign wr_any      = bus.cs & (|strobe) & ch_ok;
  assign cmd_wr      = bus.cs & bus.wr0 & ch_ok & (off == 3'd7);
  assign w1c_wr      = bus.cs & bus.wr3 & ch_ok & (off == 3'd0);
  assign snap_wr     = cmd_wr & bus.dataIn[2];
  assign unused_addr = ^bus.addr;

  logic [31:0] shadow   [NUM_CHANNELS][NREG];
  logic [31:0] active   [NUM_CHANNELS][NREG];
  logic [31:0] snapshot [NUM_CHANNELS];
  logic [31:0] ctrl_base[NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] pending, limit_err, loss_of_lock, lock_q, clear_pulse;
  logic [NUM_CHANNELS-1:0] apply_set, xfer, limit_bad, lerr_clr, lol_clr, clr_req;
  logic [31:0] rd_data, dout_q;

  // Only the writable fields of each offset are stored, so reserved bits read back as 0.
  function automatic logic [31:0] field_mask(input logic [2:0] r);
    case (r)
      3'd0:    field_mask = 32'h0000_031F;
      3'd1:    field_mask = 32'hFF1F_FF1F;
      3'd5:    field_mask = 32'h0FFF_FFFF;
      default: field_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] st);
    lane_merge = old;
    for (int b = 0; b < 4; b++)
      if (st[b]) lane_merge[8*b +: 8] = d[8*b +: 8];
  endfunction

  assign xfer = pending & loopEn;

  always_comb begin
    apply_set = '0;
    limit_bad = '0;
    lerr_clr  = '0;
    lol_clr   = '0;
    clr_req   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      limit_bad[c] = $signed(shadow[c][3]) > $signed(shadow[c][2]);
      clr_req[c]   = shadow[c][0][3];
      // clearAccum request self-clears on the transfer; a same-edge write merges on top of that.
      ctrl_base[c] = xfer[c] ? (shadow[c][0] & ~32'h8) : shadow[c][0];
      if (cmd_wr && (bus.dataIn[1] || (bus.dataIn[0] && ch == CH_BITS'(c))))
        apply_set[c] = 1'b1;
`ifdef LOOPREG_AUTO_APPLY_EN
      if (bus.cs && bus.wr3 && ch_ok && off < 3'd6 && ch == CH_BITS'(c))
        apply_set[c] = 1'b1;
`endif
      if (w1c_wr && ch == CH_BITS'(c)) begin
        lerr_clr[c] = bus.dataIn[29];
        lol_clr[c]  = bus.dataIn[30];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (ch_ok) begin
      case (off)
        3'd0:    rd_data = shadow[ch][0] | {lockStatus[ch], loss_of_lock[ch], limit_err[ch], 29'd0};
        3'd6:    rd_data = snapshot[ch];
        3'd7:    rd_data[NUM_CHANNELS-1:0] = pending;
        default: rd_data = shadow[ch][off];
      endcase
    end
  end

  always_ff @(posedge busClk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int r = 0; r < NREG; r++) begin
          shadow[c][r] <= '0;
          active[c][r] <= '0;
        end
        snapshot[c] <= '0;
      end
      pending      <= '0;
      limit_err    <= '0;
      loss_of_lock <= '0;
      lock_q       <= '0;
      clear_pulse  <= '0;
      dout_q       <= '0;
    end else begin
      dout_q       <= bus.cs ? rd_data : 32'd0;
      pending      <= (pending & ~loopEn) | apply_set;
      lock_q       <= lockStatus;
      loss_of_lock <= (loss_of_lock & ~lol_clr) | (lock_q & ~lockStatus);
      limit_err    <= (limit_err & ~lerr_clr) | (xfer & limit_bad);
      clear_pulse  <= xfer & clr_req;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (xfer[c]) begin
          active[c][0] <= shadow[c][0] & ~32'h8;
          active[c][1] <= shadow[c][1];
          active[c][4] <= shadow[c][4];
          active[c][5] <= shadow[c][5];
          // An inverted limit pair is rejected as a unit; the old limits stay in force.
          if (!limit_bad[c]) begin
            active[c][2] <= shadow[c][2];
            active[c][3] <= shadow[c][3];
          end
        end
        if (snap_wr) snapshot[c] <= lagAccum[32*c +: 32];
        shadow[c][0] <= ctrl_base[c];
        for (int r = 0; r < NREG; r++)
          if (wr_any && ch == CH_BITS'(c) && off == 3'(r))
            shadow[c][r] <= lane_merge((r == 0) ? ctrl_base[c] : shadow[c][r], bus.dataIn, strobe)
                            & field_mask(3'(r));
      end
    end
  end

  assign bus.dataOut  = dout_q;
  assign applyPending = pending;
  assign clearAccum   = clear_pulse;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_out
    logic unused_act;
    assign zeroError[g]               = active[g][0][0];
    assign invertError[g]             = active[g][0][1];
    assign ctrl2[g]                   = active[g][0][2];
    assign ctrl4[g]                   = active[g][0][4];
    assign acqTrackControl[2*g +: 2]  = active[g][0][9:8];
    assign lagExp[5*g +: 5]           = active[g][1][4:0];
    assign lagMan[8*g +: 8]           = active[g][1][15:8];
    assign leadExp[5*g +: 5]          = active[g][1][20:16];
    assign leadMan[8*g +: 8]          = active[g][1][31:24];
    assign upperLimit[32*g +: 32]     = active[g][2];
    assign lowerLimit[32*g +: 32]     = active[g][3];
    assign loopData[32*g +: 32]       = active[g][4];
    assign lockCount[16*g +: 16]      = active[g][5][15:0];
    assign syncThreshold[12*g +: 12]  = active[g][5][27:16];
    assign unused_act = ^{active[g][0][31:10], active[g][0][7:5], active[g][0][3],
                          active[g][1][23:21], active[g][1][7:5], active[g][5][31:28]};
  end
endmodule

// File: doc/loop_filter_regs_mc.md
Name: loop_filter_regs_mc

Overview:
Multi-channel, double-buffered register bank for the carrier, symbol and AGC loop filters.
- Supersedes the single-channel loop register block.
- Serves NUM_CHANNELS loop filters behind one chip-select.
- Bus writes land in per-channel shadow registers. They transfer atomically to the active outputs on an apply command, aligned to each channel's loop sample enable, so the filter never sees a half-written gain or limit.
- Adds a coherent integrator snapshot, sticky loss-of-lock and limit-sanity flags.

Parameters:
NUM_CHANNELS, 4, number of loop filter channels (1..2**CH_BITS).
CH_BITS, 2, width of the channel-select address field.
CH_SEL_LSB, 5, lowest addr bit of the channel field; addr[4:2] selects the register offset.

Ports:
busClk  in  1  bus/system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
cs  in  1  block select.
wr0, wr1, wr2, wr3  in  1 each  byte-lane write strobes, qualified by cs, sampled on busClk.
addr  in  13  byte address.
dataIn  in  32  write data.
dataOut  out  32  registered read data.
loopEn  in  NUM_CHANNELS  per-channel loop sample enable.
lagAccum  in  32*NUM_CHANNELS  live integrator values, channel c at [32c+31:32c].
lockStatus  in  NUM_CHANNELS  per-channel lock indication.
zeroError, invertError, ctrl2, ctrl4, clearAccum  out  NUM_CHANNELS each  active control bits.
acqTrackControl  out  2*NUM_CHANNELS  active acquisition/track select.
lagExp, leadExp  out  5*NUM_CHANNELS each  active gain exponents.
lagMan, leadMan  out  8*NUM_CHANNELS each  active gain mantissas.
upperLimit, lowerLimit, loopData  out  32*NUM_CHANNELS each  active signed limits and loop data.
lockCount  out  16*NUM_CHANNELS  active lock count.
syncThreshold  out  12*NUM_CHANNELS  active sync threshold.
applyPending  out  NUM_CHANNELS  shadow-to-active transfer outstanding.

Behaviour:
Reset: every shadow, active, snapshot, flag and pending bit goes to 0; dataOut goes to 0.

Register offsets (addr[4:2]):
- 0 CONTROL: b0 zeroError, b1 invertError, b2 ctrl2, b3 clearAccum, b4 ctrl4, b9:8 acqTrackControl, b29 limitErr (R, W1C), b30 lossOfLock (R, W1C), b31 lockStatus (R).
- 1 LEAD_LAG: b4:0 lagExp, b15:8 lagMan, b20:16 leadExp, b31:24 leadMan.
- 2 ULIMIT; 3 LLIMIT; 4 LOOPDATA.
- 5 LOCKDETECTOR: b15:0 lockCount, b27:16 syncThreshold.
- 6 INTEGRATOR: snapshot, read-only.
- 7 CMD/STATUS:
  - Write: b0 apply this channel, b1 apply all channels, b2 snapshot all integrators.
  - Read: b[NUM_CHANNELS-1:0] applyPending.

Writes:
- Each wrN writes only byte lane N of the selected channel's shadow register.
- A channel index >= NUM_CHANNELS ignores writes and reads 0.

Reads:
- dataOut is registered. It shows the register addressed while cs was high, one cycle later.
- Reserved bits read 0. Shadow values are returned, not active values.
- dataOut is 0 in the cycle after cs is low.

Apply:
- A CMD write sets pending at that edge.
- At the first subsequent edge where pending[c] & loopEn[c], all active registers of channel c load from shadow, and pending clears at the same edge.
- If a new apply arrives on the clearing edge, pending stays set.
- A shadow write on the transfer edge is not transferred; the old shadow value moves.

clearAccum:
- On transfer, if shadow b3 = 1, active clearAccum is high for exactly one busClk cycle.
- Shadow b3 self-clears on that same transfer.

Limit check:
- On transfer, if shadow lowerLimit > upperLimit (signed), active limits keep their old values.
- limitErr sets; all other fields still transfer.

lossOfLock:
- Sets on a 1->0 edge of lockStatus[c].
- W1C clears it; set wins over a simultaneous clear.

Snapshot:
- All channels' lagAccum are captured on the same edge as the b2 write. The values are coherent across channels.

Reset mid-transfer: reset wins; no transfer occurs.

Optional Feature:
Macro LOOPREG_AUTO_APPLY_EN.
- Defined: a wr3 write to offsets 0–5 of a channel also sets pending for that channel, the same as a CMD b0 write.
- Undefined: transfers occur only through explicit CMD writes.

Test Plan:
- Reset, then read every offset of channel 0 -> all reads return 0x00000000; applyPending = 0.
- Write LEAD_LAG ch1 = 0x1A0C2B05 with loopEn low -> outputs stay 0. Apply ch1 -> applyPending[1] = 1. Pulse loopEn[1] -> next edge lagExp = 5, lagMan = 0x2B, leadExp = 0x0C, leadMan = 0x1A; pending clears.
- Write ULIMIT ch2 = 0x00000010 and LLIMIT ch2 = 0x00000100, then apply -> limits unchanged, limitErr = 1. W1C b29 -> reads 0.
- Write CONTROL ch0 b3 = 1, then apply with loopEn[0] high -> clearAccum[0] high exactly 1 cycle; CONTROL readback b3 = 0.
- Drive lagAccum ch0 = 0x12345678 and ch3 = 0xFFFFFF00, write CMD b2, then change the inputs -> INTEGRATOR reads return 0x12345678 and 0xFFFFFF00.
- lockStatus[2] 1->0 on the same cycle as a W1C of b30 -> lossOfLock stays 1. With LOOPREG_AUTO_APPLY_EN defined, a wr3 write to LOOPDATA ch3 sets applyPending[3].
